// File: rtl/cic3_decimator_echip65.sv
// Third-order CIC (sinc^3) decimator for one ECHIP channel: 1-bit modulator
// stream in, unsigned OUT_W-bit word out every DECIM clocks, with debug monitor mux.
module cic3_decimator_echip65 #(
    parameter int unsigned DECIM = 256,
    parameter int unsigned OUT_W = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in,
    input  logic [3:0]       digital_monitor_sel,
    output logic [OUT_W-1:0] out
);

    localparam int unsigned CNT_W = $clog2(DECIM);

    logic [OUT_W-1:0] i1_q, i1_d;
    logic [OUT_W-1:0] i2_q, i2_d;
    logic [OUT_W-1:0] i3_q, i3_d;
    logic [OUT_W-1:0] d1_q, d1_d;
    logic [OUT_W-1:0] d2_q, d2_d;
    logic [OUT_W-1:0] d3_q, d3_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             strobe;
    logic [OUT_W-1:0] c1, c2, c3;

    // Integrators and decimation counter; wrap-around is intended, the combs undo it.
    always_comb begin
        i1_d  = i1_q + OUT_W'(in);
        i2_d  = i2_q + i1_q;
        i3_d  = i3_q + i2_q;
        cnt_d = cnt_q + CNT_W'(1);
    end

    assign strobe = (cnt_q == CNT_W'(DECIM - 1));

    // Comb section, evaluated only on the decimation strobe.
    always_comb begin
        c1   = i3_q - d1_q;
        c2   = c1 - d2_q;
        c3   = c2 - d3_q;
        d1_d = d1_q;
        d2_d = d2_q;
        d3_d = d3_q;
        y_d  = y_q;
        if (strobe) begin
            d1_d = i3_q;
            d2_d = c1;
            d3_d = c2;
            y_d  = c3;
        end
    end

    // Monitor mux, registered every clock; never feeds back into the filter.
    always_comb begin
        out_d = y_q;
        case (digital_monitor_sel)
            4'd1:    out_d = i1_q;
            4'd2:    out_d = i2_q;
            4'd3:    out_d = i3_q;
            4'd4:    out_d = OUT_W'(in);
            4'd5:    out_d = OUT_W'(cnt_q);
            4'd6:    out_d = OUT_W'(25'h1555555);
            4'd7:    out_d = OUT_W'(25'h0AAAAAA);
            default: out_d = y_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i1_q  <= '0;
            i2_q  <= '0;
            i3_q  <= '0;
            d1_q  <= '0;
            d2_q  <= '0;
            d3_q  <= '0;
            y_q   <= '0;
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            i3_q  <= i3_d;
            d1_q  <= d1_d;
            d2_q  <= d2_d;
            d3_q  <= d3_d;
            y_q   <= y_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_cic3_decimator_echip65.sv
// Self-checking bench for cic3_decimator_echip65: the reference is a direct
// convolution of the recorded bitstream with the boxcar^3 kernel.
module tb_cic3_decimator_echip65;

    localparam int unsigned OUT_W = 25;
    localparam int unsigned DECIM = 256;
    localparam int unsigned HLEN  = 3 * DECIM - 2;
    localparam int unsigned MAXC  = 8192;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in;
    logic [3:0]       sel;
    logic [OUT_W-1:0] out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;
    bit hist [MAXC];
    int h    [HLEN];

    cic3_decimator_echip65 #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in                  (in),
        .digital_monitor_sel (sel),
        .out                 (out)
    );

    always #5 clk = ~clk;

    // Edge index since reset release plus the input bit seen at each edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= 0;
        end else begin
            if (cyc < int'(MAXC)) hist[cyc] <= in;
            cyc <= cyc + 1;
        end
    end

    // Expected out with sel=0 after edge e: newest y is from strobe edge t <= e-1.
    function automatic logic [OUT_W-1:0] exp_y(int e);
        longint acc;
        int     t;
        int     idx;
        if (e < int'(DECIM)) return '0;
        t   = int'(DECIM) - 1 + int'(DECIM) * ((e - int'(DECIM)) / int'(DECIM));
        acc = 0;
        for (int j = 0; j < int'(HLEN); j++) begin
            idx = t - 3 - j;
            if (idx >= 0 && hist[idx]) acc += longint'(h[j]);
        end
        return OUT_W'(acc);
    endfunction

    // Expected integrator of given order just before edge e, from closed-form weights.
    function automatic logic [OUT_W-1:0] exp_int(int order, int e);
        longint acc;
        longint m;
        acc = 0;
        for (int s = 0; s < e; s++) begin
            if (hist[s]) begin
                m = longint'(e - s);
                if (order == 1) acc += 1;
                else if (order == 2) acc += m - 1;
                else if (m >= 2) acc += (m - 2) * (m - 1) / 2;
            end
        end
        return OUT_W'(acc);
    endfunction

    function automatic logic density_bit(int e);
        int ph;
        int tri_v;
        int thr;
        ph    = e % 1024;
        tri_v = (ph < 512) ? ph : 1023 - ph;
        thr   = 100 + tri_v * 800 / 511;
        return logic'(int'($urandom_range(0, 999)) < thr);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sel     = 4'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int e;
        @(negedge clk);
        reset_n = 1'b0;
        sel     = 4'd5;
        for (int i = 0; i < 100; i++) begin
            in = (i % 3 == 2) ? 1'bx : logic'(i % 2);
            @(negedge clk);
            n_cmp++;
            if (out !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d out=%0h expected=0", i, out);
            end
        end
        reset_n = 1'b1;
        in      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = cyc - 1;
            n_cmp++;
            if (out !== OUT_W'(e % int'(DECIM))) begin
                n_fail++;
                $display("FAIL reset_cnt e=%0d out=%0h expected=%0h", e, out, e % int'(DECIM));
            end
        end
        sel = 4'd0;
    endtask

    task automatic test_zero();
        do_reset();
        in = 1'b0;
        for (int i = 0; i < 3 * int'(DECIM) + 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out !== '0) begin
                n_fail++;
                $display("FAIL zero_input e=%0d out=%0h expected=0", cyc - 1, out);
            end
        end
    endtask

    task automatic test_full_scale();
        int           e;
        logic [OUT_W-1:0] exp;
        do_reset();
        in = 1'b1;
        for (int i = 0; i < 6 * int'(DECIM); i++) begin
            @(negedge clk);
            e   = cyc - 1;
            exp = exp_y(e);
            n_cmp++;
            if (out !== exp) begin
                n_fail++;
                $display("FAIL full_scale_model e=%0d out=%0h expected=%0h", e, out, exp);
            end
            if (e >= 4 * int'(DECIM)) begin
                n_cmp++;
                if (out !== 25'h1000000) begin
                    n_fail++;
                    $display("FAIL full_scale_settled e=%0d out=%0h expected=1000000", e, out);
                end
            end
        end
    endtask

    task automatic test_alternating();
        int           e;
        logic [OUT_W-1:0] exp;
        do_reset();
        in = 1'b0;
        for (int i = 0; i < 5 * int'(DECIM) + 4; i++) begin
            @(negedge clk);
            e   = cyc - 1;
            exp = exp_y(e);
            n_cmp++;
            if (out !== exp) begin
                n_fail++;
                $display("FAIL alternating_model e=%0d out=%0h expected=%0h", e, out, exp);
            end
            if (e >= 4 * int'(DECIM)) begin
                n_cmp++;
                if (out < 25'h07FFFFF || out > 25'h0800001) begin
                    n_fail++;
                    $display("FAIL alternating_settled e=%0d out=%0h expected=800000+/-1", e, out);
                end
            end
            in = ~in;
        end
    endtask

    task automatic test_monitor();
        int           e;
        logic [OUT_W-1:0] exp;
        logic [3:0]   seq [10];
        seq = '{4'd6, 4'd7, 4'd4, 4'd4, 4'd5, 4'd1, 4'd2, 4'd3, 4'd12, 4'd0};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in = 1'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            sel = seq[i];
            in  = 1'($urandom);
            @(negedge clk);
            e = cyc - 1;
            case (seq[i])
                4'd1:    exp = exp_int(1, e);
                4'd2:    exp = exp_int(2, e);
                4'd3:    exp = exp_int(3, e);
                4'd4:    exp = OUT_W'(hist[e]);
                4'd5:    exp = OUT_W'(e % int'(DECIM));
                4'd6:    exp = 25'h1555555;
                4'd7:    exp = 25'h0AAAAAA;
                default: exp = exp_y(e);
            endcase
            n_cmp++;
            if (out !== exp) begin
                n_fail++;
                $display("FAIL monitor_sel%0d e=%0d out=%0h expected=%0h", seq[i], e, out, exp);
            end
        end
        for (int i = 0; i < 700; i++) begin
            in = 1'($urandom);
            @(negedge clk);
            e   = cyc - 1;
            exp = exp_y(e);
            n_cmp++;
            if (out !== exp) begin
                n_fail++;
                $display("FAIL monitor_after e=%0d out=%0h expected=%0h", e, out, exp);
            end
        end
    endtask

    task automatic run_density(input int ncyc, input string tag);
        int           e;
        logic [OUT_W-1:0] exp;
        for (int i = 0; i < ncyc; i++) begin
            in = density_bit(cyc);
            @(negedge clk);
            e   = cyc - 1;
            exp = exp_y(e);
            n_cmp++;
            if (out !== exp || out > 25'h1000000) begin
                n_fail++;
                $display("FAIL %s e=%0d out=%0h expected=%0h", tag, e, out, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_density(1500, "density_run");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_clear out=%0h expected=0", out);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_density(1400, "density_resettle");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int h1 [DECIM];
        int h2 [2 * DECIM - 1];
        for (int i = 0; i < int'(DECIM); i++) h1[i] = 1;
        for (int i = 0; i < int'(2 * DECIM - 1); i++) h2[i] = 0;
        for (int i = 0; i < int'(HLEN); i++) h[i] = 0;
        for (int i = 0; i < int'(DECIM); i++)
            for (int j = 0; j < int'(DECIM); j++) h2[i + j] += h1[i];
        for (int i = 0; i < int'(2 * DECIM - 1); i++)
            for (int j = 0; j < int'(DECIM); j++) h[i + j] += h2[i];

        reset_n = 1'b0;
        in      = 1'b0;
        sel     = 4'd0;
        repeat (2) @(negedge clk);

        test_reset();
        test_zero();
        test_full_scale();
        test_alternating();
        test_monitor();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
